median_filter_sched: RTL and testbench

MEDIAN_FILTER_SCHED -- requirements
Module: median_filter_sched

---
 rtl/median_filter_sched_if.sv | 47 ++++
 rtl/median_filter_sched.sv | 149 ++++++++++++++
 tb/tb_median_filter_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_filter_sched_if.sv
// Bundle of request, engine and response signals around median_filter_sched.
// The slave modport is the scheduler itself; master is the surrounding system.
//
// Handshakes (req_vld/req_rdy, eng_in_vld/eng_in_rdy, eng_out_vld/eng_out_rdy,
// rsp_vld/rsp_rdy): a transfer happens on a rising clk edge where valid and
// ready are both high. A source holding valid keeps its payload stable until
// that edge. Ready may depend combinationally on valid.
interface median_filter_sched_if #(
    parameter int WIDTH   = 8,
    parameter int P_WIN   = 5,
    parameter int NUM_REQ = 4
);
    localparam int WIN_W = WIDTH * P_WIN * P_WIN;

    logic [NUM_REQ*WIN_W-1:0] req_win;
    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ*6-1:0]     cfg_thr;
    logic [WIN_W-1:0]         eng_win;
    logic [5:0]               eng_thr;
    logic                     eng_in_vld;
    logic                     eng_in_rdy;
    logic [WIDTH-1:0]         eng_data;
    logic                     eng_out_vld;
    logic                     eng_out_rdy;
    logic [NUM_REQ*WIDTH-1:0] rsp_data;
    logic [NUM_REQ-1:0]       rsp_vld;
    logic [NUM_REQ-1:0]       rsp_rdy;
    logic                     busy;
    logic                     err_tmo;
    logic                     err_clr;
    logic [1:0]               fsm_state;

    modport slave (
        input  req_win, req_vld, cfg_thr, eng_in_rdy, eng_data, eng_out_vld,
               rsp_rdy, err_clr,
        output req_rdy, eng_win, eng_thr, eng_in_vld, eng_out_rdy, rsp_data,
               rsp_vld, busy, err_tmo, fsm_state
    );

    modport master (
        output req_win, req_vld, cfg_thr, eng_in_rdy, eng_data, eng_out_vld,
               rsp_rdy, err_clr,
        input  req_rdy, eng_win, eng_thr, eng_in_vld, eng_out_rdy, rsp_data,
               rsp_vld, busy, err_tmo, fsm_state
    );
endinterface

// File: rtl/median_filter_sched.sv
// Round-robin scheduler sharing one median engine among NUM_REQ requesters.
// One job is in flight at a time; a channel with an unread response is skipped
// so its result is never overwritten. A watchdog abandons jobs whose engine
// result never arrives and raises a sticky err_tmo.
module median_filter_sched #(
    parameter int WIDTH   = 8,
    parameter int P_WIN   = 5,
    parameter int NUM_REQ = 4,
    parameter int TMO     = 64
) (
    input logic clk,
    input logic rst_n,
    median_filter_sched_if.slave bus
);
    localparam int WIN_W = WIDTH * P_WIN * P_WIN;
    localparam int PW    = $clog2(NUM_REQ);
    localparam int CW    = (TMO > 2) ? $clog2(TMO) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NUM_REQ);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    logic [1:0]               state;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            tag;
    logic [WIN_W-1:0]         win_reg;
    logic [5:0]               thr_reg;
    logic [CW-1:0]            wdog;
    logic [NUM_REQ-1:0]       rsp_vld_r;
    logic [NUM_REQ*WIDTH-1:0] rsp_data_r;
    logic                     err_tmo_r;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] vld_set;
    logic [PW-1:0]      grant_idx;
    logic               grant_found;
    logic [PW:0]        scan_idx;
    logic [PW:0]        tag_inc;
    logic [PW-1:0]      next_ptr;
    logic               eng_done;
    logic               tmo_hit;

    // A channel with an unread response is not eligible.
    assign elig = bus.req_vld & ~rsp_vld_r;

    // Pick the first eligible channel at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PW + 1)'(k);
            if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
            if (!grant_found && elig[scan_idx[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PW-1:0];
            end
        end
    end

    // One-hot ready for the granted channel, only while idle; also the
    // one-hot response set when the engine result is taken.
    always_comb begin
        grant_vec = '0;
        vld_set   = '0;
        if (state == S_IDLE && grant_found) grant_vec[grant_idx] = 1'b1;
        if (eng_done) vld_set[tag] = 1'b1;
    end

    assign tag_inc  = {1'b0, tag} + (PW + 1)'(1);
    assign next_ptr = (tag_inc >= NREQ_W) ? '0 : tag_inc[PW-1:0];
    assign eng_done = (state == S_WAIT) && bus.eng_out_vld;
    assign tmo_hit  = (state == S_WAIT) && !bus.eng_out_vld && (wdog == TMO_LAST);

    // Job FSM: latch the granted request, offer it to the engine, await result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            tag     <= '0;
            win_reg <= '0;
            thr_reg <= '0;
            wdog    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        win_reg <= bus.req_win[grant_idx*WIN_W +: WIN_W];
                        thr_reg <= bus.cfg_thr[grant_idx*6 +: 6];
                        tag     <= grant_idx;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.eng_in_rdy) begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_done || tmo_hit) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response slots: cleared when consumed, written when the engine answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r  <= '0;
            rsp_data_r <= '0;
        end else begin
            rsp_vld_r <= (rsp_vld_r & ~bus.rsp_rdy) | vld_set;
            if (eng_done) rsp_data_r[tag*WIDTH +: WIDTH] <= bus.eng_data;
        end
    end

    // Sticky timeout flag; a new timeout wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tmo_r <= 1'b0;
        end else if (tmo_hit) begin
            err_tmo_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_tmo_r <= 1'b0;
        end
    end

    assign bus.req_rdy     = grant_vec;
    assign bus.eng_win     = win_reg;
    assign bus.eng_thr     = thr_reg;
    assign bus.eng_in_vld  = (state == S_ISSUE);
    assign bus.eng_out_rdy = (state != S_IDLE);
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_vld     = rsp_vld_r;
    assign bus.busy        = (state != S_IDLE);
    assign bus.err_tmo     = err_tmo_r;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_median_filter_sched.sv
// Directed bench for median_filter_sched: a behavioural median engine, request
// drivers, and a monitor that checks grants and responses against queues of
// expected values filled by the stimulus.
module tb_median_filter_sched;
    localparam int W     = 8;
    localparam int P     = 5;
    localparam int N     = 4;
    localparam int TMO   = 64;
    localparam int WIN_W = W * P * P;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic clk;
    logic rst_n;

    median_filter_sched_if #(.WIDTH(W), .P_WIN(P), .NUM_REQ(N)) bus ();

    median_filter_sched #(.WIDTH(W), .P_WIN(P), .NUM_REQ(N), .TMO(TMO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];     // {channel[2:0], expected median}
    int          grant_q[$];   // expected grant order
    int          n_cmp = 0;
    int          n_mis = 0;
    int          eng_stall = 0;
    int          eng_lat = 0;
    bit          eng_mute = 1'b0;
    int          done3 = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] win_flat(input logic [7:0] pix, input logic [7:0] center);
        logic [WIN_W-1:0] w;
        for (int k = 0; k < P * P; k++) w[k*8 +: 8] = pix;
        w[12*8 +: 8] = center;
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] win_ramp(input logic [7:0] base, input bit desc);
        logic [WIN_W-1:0] w;
        for (int k = 0; k < P * P; k++) w[k*8 +: 8] = desc ? base + 8'(24 - k) : base + 8'(k);
        return w;
    endfunction

    function automatic logic [7:0] median_of(input logic [WIN_W-1:0] w);
        int v[25];
        int t;
        for (int k = 0; k < 25; k++) v[k] = int'(w[k*8 +: 8]);
        for (int a = 0; a < 24; a++)
            for (int b = 0; b < 24 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        return 8'(v[12]);
    endfunction

    // ---------------- engine model ----------------
    initial begin
        logic [WIN_W-1:0] cap;
        bool_loop: forever begin
            @(negedge clk);
            if (rst_n && bus.eng_in_vld) begin
                repeat (eng_stall) @(negedge clk);
                cap = bus.eng_win;
                bus.eng_in_rdy = 1'b1;
                @(posedge clk);
                #1 bus.eng_in_rdy = 1'b0;
                if (!eng_mute) begin
                    repeat (eng_lat) @(posedge clk);
                    #1;
                    bus.eng_out_vld = 1'b1;
                    bus.eng_data    = median_of(cap);
                    for (int c = 0; c < 20; c++) begin
                        @(negedge clk);
                        if (bus.eng_out_rdy) break;
                    end
                    @(posedge clk);
                    #1 bus.eng_out_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int ch, input logic [WIN_W-1:0] win, input logic [5:0] thr,
                        input logic [7:0] exp_med, input bit expect_rsp);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.req_win[ch*WIN_W +: WIN_W] = win;
        bus.cfg_thr[ch*6 +: 6]         = thr;
        bus.req_vld[ch]                = 1'b1;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            if (bus.req_rdy[ch]) got = 1'b1;
        end
        chk($sformatf("grant_wait_ch%0d", ch), 256'(got), 256'(1));
        @(posedge clk);
        #1 bus.req_vld[ch] = 1'b0;
        if (got && expect_rsp) exp_q.push_back({3'(ch), exp_med});
    endtask

    task automatic drain(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) got = 1'b1;
        end
        chk({name, "_drain"}, 256'(got), 256'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        grant_q.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin
        int idx;
        int g;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.rsp_vld[i] && bus.rsp_rdy[i]) begin
                        idx = -1;
                        for (int j = 0; j < exp_q.size(); j++)
                            if (idx < 0 && exp_q[j][10:8] == 3'(i)) idx = j;
                        if (idx < 0) begin
                            n_cmp++;
                            n_mis++;
                            $display("FAIL rsp_unexpected: ch%0d data %0h, required no response",
                                     i, bus.rsp_data[i*W +: W]);
                        end else begin
                            chk($sformatf("rsp_data_ch%0d", i), 256'(bus.rsp_data[i*W +: W]),
                                256'(exp_q[idx][7:0]));
                            exp_q.delete(idx);
                        end
                    end
                end
                if (bus.req_rdy != '0) begin
                    if (grant_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL grant_unexpected: req_rdy %0h, required 0", bus.req_rdy);
                    end else begin
                        g = grant_q.pop_front();
                        chk("grant_order", 256'(bus.req_rdy), 256'(1) << g);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit got;
        int wcnt;
        int hold_cnt;
        logic [WIN_W-1:0] w0;

        rst_n           = 1'b0;
        bus.req_win     = '0;
        bus.req_vld     = '0;
        bus.cfg_thr     = '0;
        bus.eng_in_rdy  = 1'b0;
        bus.eng_data    = '0;
        bus.eng_out_vld = 1'b0;
        bus.rsp_rdy     = '1;
        bus.err_clr     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 256'(bus.req_rdy), 256'(0));
        chk("rst_eng_in_vld", 256'(bus.eng_in_vld), 256'(0));
        chk("rst_eng_out_rdy", 256'(bus.eng_out_rdy), 256'(0));
        chk("rst_rsp_vld", 256'(bus.rsp_vld), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_err_tmo", 256'(bus.err_tmo), 256'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single job on channel 2: outlier centre is rejected by the median.
        grant_q.push_back(2);
        send(2, win_flat(8'h40, 8'hFF), 6'd12, 8'h40, 1'b1);
        @(negedge clk);
        chk("lat_eng_in_vld", 256'(bus.eng_in_vld), 256'(1));
        chk("eng_thr_grant", 256'(bus.eng_thr), 256'(12));
        chk("eng_win_grant", 256'(bus.eng_win), 256'(win_flat(8'h40, 8'hFF)));
        drain("single");

        // Fairness: all channels busy, served in rotation from 0.
        do_reset();
        eng_stall = 2;
        eng_lat   = 3;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N; c++) grant_q.push_back(c);
        fork
            begin
                send(0, win_ramp(8'h10, 1'b0), 6'd1, 8'h1C, 1'b1);
                send(0, win_flat(8'h07, 8'h00), 6'd2, 8'h07, 1'b1);
            end
            begin
                send(1, win_ramp(8'h30, 1'b1), 6'd3, 8'h3C, 1'b1);
                send(1, win_flat(8'hE3, 8'h01), 6'd4, 8'hE3, 1'b1);
            end
            begin
                send(2, win_ramp(8'h50, 1'b0), 6'd5, 8'h5C, 1'b1);
                send(2, win_ramp(8'h00, 1'b0), 6'd6, 8'h0C, 1'b1);
            end
            begin
                send(3, win_ramp(8'hC0, 1'b1), 6'd7, 8'hCC, 1'b1);
                send(3, win_ramp(8'hE7, 1'b0), 6'd63, 8'hF3, 1'b1);
            end
        join
        drain("fair");
        eng_stall = 0;
        eng_lat   = 1;

        // Backpressure: channel 1 holds its response, others keep flowing.
        bus.rsp_rdy[1] = 1'b0;
        grant_q.push_back(1);
        send(1, win_flat(8'h99, 8'h99), 6'd9, 8'h99, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_vld[1]) got = 1'b1;
        end
        chk("bp_first_rsp", 256'(got), 256'(1));
        grant_q.push_back(2);
        grant_q.push_back(3);
        grant_q.push_back(0);
        grant_q.push_back(1);
        done3 = 0;
        fork
            begin send(0, win_ramp(8'h20, 1'b0), 6'd10, 8'h2C, 1'b1); done3++; end
            begin send(2, win_flat(8'h55, 8'hAA), 6'd11, 8'h55, 1'b1); done3++; end
            begin send(3, win_ramp(8'h60, 1'b1), 6'd13, 8'h6C, 1'b1); done3++; end
            send(1, win_flat(8'h11, 8'hFF), 6'd14, 8'h11, 1'b1);
            begin
                got = 1'b0;
                for (int c = 0; c < 600 && !got; c++) begin
                    @(negedge clk);
                    if (done3 == 3 && exp_q.size() == 1 && !bus.busy) got = 1'b1;
                end
                chk("bp_others_done", 256'(got), 256'(1));
                chk("bp_rsp_data_held", 256'(bus.rsp_data[1*W +: W]), 256'(8'h99));
                chk("bp_rsp_vld_held", 256'(bus.rsp_vld[1]), 256'(1));
                @(posedge clk);
                #1 bus.rsp_rdy[1] = 1'b1;
            end
        join
        drain("bp");

        // Threshold and window hold while the channel changes its inputs.
        eng_lat = 10;
        w0 = win_ramp(8'h80, 1'b0);
        grant_q.push_back(0);
        send(0, w0, 6'd20, 8'h8C, 1'b1);
        bus.cfg_thr[5:0] = 6'd33;
        bus.req_win[WIN_W-1:0] = win_flat(8'h01, 8'h02);
        hold_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
            hold_cnt++;
            chk("thr_hold", 256'(bus.eng_thr), 256'(20));
            chk("win_hold", 256'(bus.eng_win), 256'(w0));
        end
        chk("thr_hold_span", 256'(hold_cnt >= 10), 256'(1));
        drain("thr");
        eng_lat = 1;

        // Timeout: engine never answers channel 1.
        eng_mute = 1'b1;
        grant_q.push_back(1);
        send(1, win_flat(8'h22, 8'h22), 6'd5, 8'h00, 1'b0);
        wcnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.fsm_state == S_WAIT) wcnt++;
            if (!bus.busy) break;
        end
        chk("tmo_wait_cycles", 256'(wcnt), 256'(TMO));
        chk("tmo_err", 256'(bus.err_tmo), 256'(1));
        chk("tmo_busy", 256'(bus.busy), 256'(0));
        chk("tmo_rsp_vld", 256'(bus.rsp_vld), 256'(0));
        eng_mute = 1'b0;
        grant_q.push_back(2);
        grant_q.push_back(0);
        fork
            send(2, win_flat(8'h33, 8'h33), 6'd6, 8'h33, 1'b1);
            send(0, win_flat(8'h44, 8'h00), 6'd7, 8'h44, 1'b1);
        join
        drain("tmo_next");
        chk("tmo_sticky", 256'(bus.err_tmo), 256'(1));
        @(posedge clk);
        #1 bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", 256'(bus.err_tmo), 256'(0));

        // Timeout and clear in the same cycle: the set wins.
        bus.err_clr = 1'b1;
        eng_mute    = 1'b1;
        grant_q.push_back(3);
        send(3, win_flat(8'h66, 8'h66), 6'd8, 8'h00, 1'b0);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        chk("tmo_set_wins", 256'(bus.err_tmo), 256'(1));
        @(negedge clk);
        chk("tmo_clr_after", 256'(bus.err_tmo), 256'(0));
        bus.err_clr = 1'b0;

        // Reset in WAIT abandons the job; a late engine result is ignored.
        grant_q.push_back(0);
        send(0, win_flat(8'h70, 8'h70), 6'd9, 8'h00, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus.fsm_state == S_WAIT) got = 1'b1;
        end
        chk("rst_job_wait", 256'(got), 256'(1));
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_req_rdy", 256'(bus.req_rdy), 256'(0));
        chk("rstw_eng_in_vld", 256'(bus.eng_in_vld), 256'(0));
        chk("rstw_eng_out_rdy", 256'(bus.eng_out_rdy), 256'(0));
        chk("rstw_rsp_vld", 256'(bus.rsp_vld), 256'(0));
        chk("rstw_rsp_data", 256'(bus.rsp_data), 256'(0));
        chk("rstw_busy", 256'(bus.busy), 256'(0));
        chk("rstw_err_tmo", 256'(bus.err_tmo), 256'(0));
        chk("rstw_eng_thr", 256'(bus.eng_thr), 256'(0));
        chk("rstw_eng_win", 256'(bus.eng_win), 256'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        eng_mute = 1'b0;
        @(posedge clk);
        #1;
        bus.eng_out_vld = 1'b1;
        bus.eng_data    = 8'hAB;
        repeat (3) @(posedge clk);
        #1 bus.eng_out_vld = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("late_rsp_vld", 256'(bus.rsp_vld), 256'(0));
            chk("late_busy", 256'(bus.busy), 256'(0));
        end

        chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
        chk("grant_q_empty", 256'(grant_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
